al_accel_elw_issuer: RTL and testbench

Initiator side of the element-wise quantize/activation lane handshake. Accepts groups of three 32-bit accumulators from the PE array, drives them into the three quantize/activation lanes of the element-wise unit with per-lane enb/rdy, collects the 8-bit results, packs them little-endian into 32-bit words, and writes those words to the output buffer. It sits between the accumulator drain and the output-buffer write port.

---
 rtl/al_accel_pkg.sv | 32 +++
 rtl/al_accel_byte_packer.sv | 80 ++++++++
 rtl/al_accel_elw_issuer.sv | 170 +++++++++++++++++
 tb/tb_al_accel_elw_issuer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/al_accel_pkg.sv
// Shared definitions for the element-wise issuer: FSM states, lane count and
// output-buffer byte-enable patterns.
package al_accel_pkg;

    localparam int NUM_LANES = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_PACK  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_1    = 4'b0001;
    localparam logic [3:0] BE_2    = 4'b0011;
    localparam logic [3:0] BE_3    = 4'b0111;
    localparam logic [3:0] BE_FULL = 4'b1111;

    // Byte enables for a partial word holding n valid low-order bytes
    function automatic logic [3:0] be_for_count(input logic [1:0] n);
        case (n)
            2'd1:    return BE_1;
            2'd2:    return BE_2;
            2'd3:    return BE_3;
            default: return BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/al_accel_byte_packer.sv
// Little-endian byte packer: keeps up to 3 residual bytes, appends 0..3 new
// bytes per group, emits a full word once 4 bytes are available, and writes
// out a zero-padded partial word on flush.
module al_accel_byte_packer
    import al_accel_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        append,
    input  logic [23:0] in_bytes,
    input  logic [1:0]  in_cnt,
    input  logic        flush,
    output logic        wr_fire,
    output logic        ob_we,
    output logic [31:0] ob_wdata,
    output logic [3:0]  ob_be
);

    logic [23:0] res_reg, res_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [31:0] wdata_next;
    logic [3:0]  be_next;
    logic [47:0] merged;
    logic [2:0]  total;

    // New bytes land directly above the residual ones
    assign merged = {24'd0, res_reg} | ({24'd0, in_bytes} << {cnt_reg, 3'b000});
    assign total  = {1'b0, cnt_reg} + {1'b0, in_cnt};

    // Residual update and write decision
    always_comb begin
        res_next   = res_reg;
        cnt_next   = cnt_reg;
        wr_fire    = 1'b0;
        wdata_next = 32'd0;
        be_next    = BE_NONE;
        if (clear) begin
            res_next = 24'd0;
            cnt_next = 2'd0;
        end else if (append) begin
            if (total >= 3'd4) begin
                wr_fire    = 1'b1;
                wdata_next = merged[31:0];
                be_next    = BE_FULL;
                res_next   = {8'd0, merged[47:32]};
                cnt_next   = 2'(total - 3'd4);
            end else begin
                res_next = merged[23:0];
                cnt_next = total[1:0];
            end
        end else if (flush) begin
            if (cnt_reg != 2'd0) begin
                wr_fire    = 1'b1;
                wdata_next = {8'd0, res_reg};
                be_next    = be_for_count(cnt_reg);
            end
            res_next = 24'd0;
            cnt_next = 2'd0;
        end
    end

    // Residual state and registered write port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_reg  <= 24'd0;
            cnt_reg  <= 2'd0;
            ob_we    <= 1'b0;
            ob_wdata <= 32'd0;
            ob_be    <= BE_NONE;
        end else begin
            res_reg  <= res_next;
            cnt_reg  <= cnt_next;
            ob_we    <= wr_fire;
            ob_wdata <= wdata_next;
            ob_be    <= be_next;
        end
    end

endmodule

// File: rtl/al_accel_elw_issuer.sv
// Element-wise lane issuer: fetches accumulator groups, runs the per-lane
// enb/rdy handshake, and hands the captured bytes to the byte packer that
// writes the output buffer.
module al_accel_elw_issuer
    import al_accel_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_grp,
    input  logic [2:0]        cfg_lane_mask,
    input  logic [ADDR_W-1:0] cfg_ob_base,
    output logic              busy,
    output logic              done,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [31:0]       acc_d0,
    input  logic [31:0]       acc_d1,
    input  logic [31:0]       acc_d2,
    output logic [31:0]       elew_di_0_0,
    output logic [31:0]       elew_di_0_1,
    output logic [31:0]       elew_di_0_2,
    output logic              quant_act_func_enb_0,
    output logic              quant_act_func_enb_1,
    output logic              quant_act_func_enb_2,
    input  logic              quant_act_func_rdy_0,
    input  logic              quant_act_func_rdy_1,
    input  logic              quant_act_func_rdy_2,
    input  logic [7:0]        elew_do_0_0,
    input  logic [7:0]        elew_do_0_1,
    input  logic [7:0]        elew_do_0_2,
    output logic              ob_we,
    output logic [ADDR_W-1:0] ob_addr,
    output logic [31:0]       ob_wdata,
    output logic [3:0]        ob_be
);

    state_t              state_reg;
    logic [CNT_W-1:0]    num_grp_reg, grp_cnt_reg, grp_cnt_inc;
    logic [2:0]          mask_reg;
    logic [ADDR_W-1:0]   addr_reg, ob_addr_reg;
    logic [2:0]          enb_reg, lane_done_reg, rdy_vec, hs_vec;
    logic [31:0]         acc_arr [NUM_LANES];
    logic [31:0]         di_reg  [NUM_LANES];
    logic [7:0]          do_arr  [NUM_LANES];
    logic [7:0]          cap_reg [NUM_LANES];
    logic                start_ok, acc_fire, all_done, wr_fire;
    logic [23:0]         pk_bytes;
    logic [1:0]          pk_cnt;

    assign acc_arr[0] = acc_d0;
    assign acc_arr[1] = acc_d1;
    assign acc_arr[2] = acc_d2;
    assign do_arr[0]  = elew_do_0_0;
    assign do_arr[1]  = elew_do_0_1;
    assign do_arr[2]  = elew_do_0_2;
    assign rdy_vec    = {quant_act_func_rdy_2, quant_act_func_rdy_1, quant_act_func_rdy_0};

    assign elew_di_0_0 = di_reg[0];
    assign elew_di_0_1 = di_reg[1];
    assign elew_di_0_2 = di_reg[2];
    assign quant_act_func_enb_0 = enb_reg[0];
    assign quant_act_func_enb_1 = enb_reg[1];
    assign quant_act_func_enb_2 = enb_reg[2];
    assign ob_addr = ob_addr_reg;

    assign start_ok    = (state_reg == ST_IDLE) && start;
    assign acc_ready   = (state_reg == ST_FETCH);
    assign acc_fire    = acc_valid && acc_ready;
    assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done        = (state_reg == ST_DONE);
    assign hs_vec      = enb_reg & rdy_vec;
    // A lane finishing in this very cycle counts as done so PACK follows the last rdy
    assign all_done    = ((lane_done_reg | hs_vec) & mask_reg) == mask_reg;
    assign grp_cnt_inc = grp_cnt_reg + 1'b1;

    // Group sequencing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            num_grp_reg <= '0;
            mask_reg    <= 3'd0;
            grp_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (start) begin
                    num_grp_reg <= cfg_num_grp;
                    mask_reg    <= cfg_lane_mask;
                    grp_cnt_reg <= '0;
                    state_reg   <= (cfg_num_grp == '0 || cfg_lane_mask == 3'd0) ? ST_FLUSH : ST_FETCH;
                end
                ST_FETCH: if (acc_valid) state_reg <= ST_ISSUE;
                ST_ISSUE: if (all_done) state_reg <= ST_PACK;
                ST_PACK: begin
                    grp_cnt_reg <= grp_cnt_inc;
                    state_reg   <= (grp_cnt_inc == num_grp_reg) ? ST_FLUSH : ST_FETCH;
                end
                ST_FLUSH: state_reg <= ST_DONE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    // Operand registers and per-lane request/complete handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enb_reg       <= 3'd0;
            lane_done_reg <= 3'd0;
            for (int i = 0; i < NUM_LANES; i++) begin
                di_reg[i]  <= 32'd0;
                cap_reg[i] <= 8'd0;
            end
        end else if (acc_fire) begin
            enb_reg       <= mask_reg;
            lane_done_reg <= 3'd0;
            for (int i = 0; i < NUM_LANES; i++) di_reg[i] <= acc_arr[i];
        end else if (state_reg == ST_ISSUE) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (hs_vec[i]) begin
                    cap_reg[i]       <= do_arr[i];
                    lane_done_reg[i] <= 1'b1;
                    enb_reg[i]       <= 1'b0;
                end
            end
        end
    end

    // Compact the captured bytes of masked lanes, lane 0 first
    always_comb begin
        pk_bytes = 24'd0;
        pk_cnt   = 2'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mask_reg[i]) begin
                pk_bytes = pk_bytes | (24'(cap_reg[i]) << {pk_cnt, 3'b000});
                pk_cnt   = pk_cnt + 2'd1;
            end
        end
    end

    // Write address: reloaded at start, advanced after every emitted word
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_reg    <= '0;
            ob_addr_reg <= '0;
        end else if (start_ok) begin
            addr_reg <= cfg_ob_base;
        end else if (wr_fire) begin
            ob_addr_reg <= addr_reg;
            addr_reg    <= addr_reg + 1'b1;
        end
    end

    al_accel_byte_packer u_packer (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (start_ok),
        .append   (state_reg == ST_PACK),
        .in_bytes (pk_bytes),
        .in_cnt   (pk_cnt),
        .flush    (state_reg == ST_FLUSH),
        .wr_fire  (wr_fire),
        .ob_we    (ob_we),
        .ob_wdata (ob_wdata),
        .ob_be    (ob_be)
    );

endmodule

// File: tb/tb_al_accel_elw_issuer.sv
// Randomized bench for al_accel_elw_issuer with a byte-stream reference model.
module tb_al_accel_elw_issuer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_num_grp = '0;
    logic [2:0]  cfg_lane_mask = '0;
    logic [15:0] cfg_ob_base = '0;
    logic        busy, done, acc_ready;
    logic        acc_valid = 1'b0;
    logic [31:0] acc_d0 = '0, acc_d1 = '0, acc_d2 = '0;
    logic [31:0] elew_di_0_0, elew_di_0_1, elew_di_0_2;
    logic        quant_act_func_enb_0, quant_act_func_enb_1, quant_act_func_enb_2;
    logic        rdy_tb [3];
    logic [7:0]  do_tb [3];
    logic        ob_we;
    logic [15:0] ob_addr;
    logic [31:0] ob_wdata;
    logic [3:0]  ob_be;
    logic [2:0]  enb_v;

    always #5 clk = ~clk;
    assign enb_v = {quant_act_func_enb_2, quant_act_func_enb_1, quant_act_func_enb_0};

    al_accel_elw_issuer #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .cfg_num_grp(cfg_num_grp), .cfg_lane_mask(cfg_lane_mask), .cfg_ob_base(cfg_ob_base),
        .busy(busy), .done(done), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_d0(acc_d0), .acc_d1(acc_d1), .acc_d2(acc_d2),
        .elew_di_0_0(elew_di_0_0), .elew_di_0_1(elew_di_0_1), .elew_di_0_2(elew_di_0_2),
        .quant_act_func_enb_0(quant_act_func_enb_0), .quant_act_func_enb_1(quant_act_func_enb_1),
        .quant_act_func_enb_2(quant_act_func_enb_2),
        .quant_act_func_rdy_0(rdy_tb[0]), .quant_act_func_rdy_1(rdy_tb[1]), .quant_act_func_rdy_2(rdy_tb[2]),
        .elew_do_0_0(do_tb[0]), .elew_do_0_1(do_tb[1]), .elew_do_0_2(do_tb[2]),
        .ob_we(ob_we), .ob_addr(ob_addr), .ob_wdata(ob_wdata), .ob_be(ob_be)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane results per group, lane response delays (-1 = random), job tag
    logic [7:0] res [64][3];
    int         lane_dly [3];
    int         job_id = 0;
    bit         noise_en = 1'b0;

    // Monitor state (written only by the monitor process)
    int          cyc = 0, done_cnt = 0, done_cyc = 0, enb1_cnt = 0, viol_cnt = 0, skew_cnt = 0;
    logic [15:0] wa_q [$];
    logic [31:0] wd_q [$];
    logic [3:0]  wb_q [$];

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        logic [2:0] prev_enb;
        logic [2:0] hs;
        prev_enb = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (resetn) begin
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (ob_we) begin
                    wa_q.push_back(ob_addr);
                    wd_q.push_back(ob_wdata);
                    wb_q.push_back(ob_be);
                end
                if (quant_act_func_enb_1) enb1_cnt++;
                hs = prev_enb & {rdy_tb[2], rdy_tb[1], rdy_tb[0]};
                if ((hs & enb_v) != 3'd0) viol_cnt++;
                if (acc_ready && enb_v != 3'd0) viol_cnt++;
                if (quant_act_func_enb_0 && !quant_act_func_enb_2) skew_cnt++;
            end
            prev_enb = enb_v;
        end
    end

    // Lane responders: rdy pulse after a delay, plus stray rdy while enb is low
    initial begin
        int wcnt [3];
        int hsn [3];
        int last_job;
        last_job = -1;
        for (int i = 0; i < 3; i++) begin
            rdy_tb[i] = 1'b0;
            do_tb[i]  = 8'd0;
            wcnt[i]   = -1;
            hsn[i]    = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            if (job_id != last_job) begin
                last_job = job_id;
                for (int i = 0; i < 3; i++) hsn[i] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                rdy_tb[i] = 1'b0;
                do_tb[i]  = 8'($urandom);
                if (enb_v[i]) begin
                    if (wcnt[i] == -1) wcnt[i] = (lane_dly[i] < 0) ? int'($urandom_range(0, 4)) : lane_dly[i];
                    if (wcnt[i] == 0) begin
                        rdy_tb[i] = 1'b1;
                        do_tb[i]  = res[hsn[i] % 64][i];
                        hsn[i]++;
                        wcnt[i] = -2;
                    end else if (wcnt[i] > 0) begin
                        wcnt[i]--;
                    end
                end else begin
                    wcnt[i] = -1;
                    if (noise_en && $urandom_range(0, 3) == 0) rdy_tb[i] = 1'b1;
                end
            end
        end
    end

    // One job: model the output stream from the byte sequence, drive, compare
    task automatic run_job(input int num, input logic [2:0] mask, input logic [15:0] base, input bit stray);
        logic [7:0]  bq [$];
        logic [15:0] ea [$];
        logic [31:0] ed [$];
        logic [3:0]  eb [$];
        logic [31:0] exp_di [3];
        logic [31:0] w;
        logic [15:0] a;
        int w0, d0, v0, c0, budget;
        bit got_done, di_pend;

        a = base;
        if (num > 0 && mask != 3'd0) begin
            for (int g = 0; g < num; g++) begin
                for (int i = 0; i < 3; i++) if (mask[i]) bq.push_back(res[g][i]);
                if (bq.size() >= 4) begin
                    ed.push_back({bq[3], bq[2], bq[1], bq[0]});
                    eb.push_back(4'hF);
                    ea.push_back(a);
                    a = a + 16'd1;
                    repeat (4) void'(bq.pop_front());
                end
            end
            if (bq.size() > 0) begin
                w = 32'd0;
                for (int j = 0; j < bq.size(); j++) w = w | (32'(bq[j]) << (8 * j));
                ed.push_back(w);
                eb.push_back(4'((1 << bq.size()) - 1));
                ea.push_back(a);
            end
        end

        job_id++;
        w0 = wa_q.size();
        d0 = done_cnt;
        v0 = viol_cnt;
        @(negedge clk);
        start = 1'b1;
        cfg_num_grp = 16'(num);
        cfg_lane_mask = mask;
        cfg_ob_base = base;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        cfg_num_grp = 16'($urandom);
        cfg_lane_mask = 3'($urandom);
        cfg_ob_base = 16'($urandom);
        check_eq("busy_after_start", 64'(busy), 64'd1);

        budget = 0;
        got_done = 1'b0;
        di_pend = 1'b0;
        while (!got_done && budget < 3000) begin
            start = 1'b0;
            if (di_pend) begin
                check_eq("di0", 64'(elew_di_0_0), 64'(exp_di[0]));
                check_eq("di1", 64'(elew_di_0_1), 64'(exp_di[1]));
                check_eq("di2", 64'(elew_di_0_2), 64'(exp_di[2]));
                di_pend = 1'b0;
            end
            if (done_cnt > d0) begin
                got_done = 1'b1;
            end else begin
                acc_valid = ($urandom_range(0, 2) != 0);
                acc_d0 = $urandom;
                acc_d1 = $urandom;
                acc_d2 = $urandom;
                if (acc_valid && acc_ready) begin
                    di_pend = 1'b1;
                    exp_di[0] = acc_d0;
                    exp_di[1] = acc_d1;
                    exp_di[2] = acc_d2;
                end
                if (stray && $urandom_range(0, 15) == 0) start = 1'b1;
                @(negedge clk);
                budget++;
            end
        end
        check_eq("done_seen", 64'(got_done), 64'd1);
        acc_valid = 1'b0;
        if (num == 0 || mask == 3'd0) check_eq("done_latency", 64'(done_cyc - c0), 64'd2);
        // A start in the done cycle must be ignored
        if (stray) begin
            start = 1'b1;
            cfg_num_grp = 16'd1;
            cfg_lane_mask = 3'b111;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_after_done", 64'(busy), 64'd0);
        check_eq("done_pulses", 64'(done_cnt - d0), 64'd1);
        check_eq("handshake_rules", 64'(viol_cnt - v0), 64'd0);
        check_eq("write_count", 64'(wa_q.size() - w0), 64'(ea.size()));
        for (int k = 0; k < ea.size() && (w0 + k) < wa_q.size(); k++) begin
            check_eq($sformatf("wr%0d_addr", k), 64'(wa_q[w0 + k]), 64'(ea[k]));
            check_eq($sformatf("wr%0d_data", k), 64'(wd_q[w0 + k]), 64'(ed[k]));
            check_eq($sformatf("wr%0d_be", k), 64'(wb_q[w0 + k]), 64'(eb[k]));
        end
    endtask

    initial begin
        int w, e1, sk, d0, budget;
        for (int i = 0; i < 3; i++) lane_dly[i] = 2;
        for (int g = 0; g < 64; g++) for (int i = 0; i < 3; i++) res[g][i] = 8'd0;

        // Reset holds everything quiet even with acc_valid high
        resetn = 1'b0;
        acc_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_acc_ready", 64'(acc_ready), 64'd0);
        check_eq("rst_enb", 64'(enb_v), 64'd0);
        check_eq("rst_ob_we", 64'(ob_we), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_di0", 64'(elew_di_0_0), 64'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_eq("post_rst_acc_ready", 64'(acc_ready), 64'd0);
        acc_valid = 1'b0;

        // Four full groups, bytes 01..0C, three full words
        for (int g = 0; g < 4; g++) for (int i = 0; i < 3; i++) res[g][i] = 8'(g * 3 + i + 1);
        w = wa_q.size();
        run_job(4, 3'b111, 16'h0010, 1'b0);
        if (wd_q.size() > w + 2) begin
            check_eq("seq_word0", 64'(wd_q[w]), 64'h04030201);
            check_eq("seq_word2", 64'(wd_q[w + 2]), 64'h0C0B0A09);
        end

        // Single group: partial flush
        res[0][0] = 8'hAA; res[0][1] = 8'hBB; res[0][2] = 8'hCC;
        w = wa_q.size();
        run_job(1, 3'b111, 16'h0020, 1'b0);
        if (wd_q.size() > w) begin
            check_eq("flush_word", 64'(wd_q[w]), 64'h00CCBBAA);
            check_eq("flush_be", 64'(wb_q[w]), 64'h7);
        end

        // Skewed lanes
        lane_dly[0] = 5; lane_dly[1] = 3; lane_dly[2] = 1;
        for (int g = 0; g < 2; g++) for (int i = 0; i < 3; i++) res[g][i] = 8'($urandom);
        sk = skew_cnt;
        run_job(2, 3'b111, 16'h0030, 1'b0);
        check_eq("skew_enb0_outlives_enb2", 64'(skew_cnt > sk), 64'd1);

        // Lane 1 masked off
        lane_dly[0] = 1; lane_dly[1] = 1; lane_dly[2] = 2;
        res[0][0] = 8'h11; res[0][1] = 8'h22; res[0][2] = 8'h33;
        res[1][0] = 8'h44; res[1][1] = 8'h55; res[1][2] = 8'h66;
        w = wa_q.size();
        e1 = enb1_cnt;
        run_job(2, 3'b101, 16'h0040, 1'b0);
        check_eq("enb1_never", 64'(enb1_cnt - e1), 64'd0);
        if (wd_q.size() > w) check_eq("mask101_word", 64'(wd_q[w]), 64'h66443311);

        // Empty jobs and address wrap
        run_job(0, 3'b111, 16'h0050, 1'b0);
        run_job(3, 3'b000, 16'h0060, 1'b0);
        for (int g = 0; g < 4; g++) for (int i = 0; i < 3; i++) res[g][i] = 8'($urandom);
        run_job(4, 3'b111, 16'hFFFF, 1'b0);

        // Randomized jobs with stray rdy and stray starts
        noise_en = 1'b1;
        for (int i = 0; i < 3; i++) lane_dly[i] = -1;
        for (int t = 0; t < 12; t++) begin
            for (int g = 0; g < 8; g++) for (int i = 0; i < 3; i++) res[g][i] = 8'($urandom);
            run_job(int'($urandom_range(0, 7)), 3'($urandom), 16'($urandom), 1'b1);
        end

        // Reset while lanes are being issued
        noise_en = 1'b0;
        for (int i = 0; i < 3; i++) lane_dly[i] = 6;
        job_id++;
        @(negedge clk);
        start = 1'b1;
        cfg_num_grp = 16'd3;
        cfg_lane_mask = 3'b111;
        cfg_ob_base = 16'h0070;
        @(negedge clk);
        start = 1'b0;
        acc_valid = 1'b1;
        budget = 0;
        while (enb_v == 3'd0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("enb_before_reset", 64'(enb_v), 64'h7);
        w = wa_q.size();
        d0 = done_cnt;
        resetn = 1'b0;
        acc_valid = 1'b0;
        #1;
        check_eq("enb_async_drop", 64'(enb_v), 64'd0);
        check_eq("busy_async_drop", 64'(busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("reset_no_write", 64'(wa_q.size() - w), 64'd0);
        check_eq("reset_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("reset_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
